// File: rtl/mem_io_responder_if.sv
// CPU byte-bus interface between the CPU (master) and the memory/I-O responder (slave).
// Carries address, write data, write strobe, registered read data and the TX back-pressure flag.
interface mem_io_responder_if;
  logic [31:0] bus_a;
  logic [7:0]  bus_dout;
  logic        bus_wr;
  logic [7:0]  bus_din;
  logic        io_buffer_full;

  modport master (
    output bus_a,
    output bus_dout,
    output bus_wr,
    input  bus_din,
    input  io_buffer_full
  );

  modport slave (
    input  bus_a,
    input  bus_dout,
    input  bus_wr,
    output bus_din,
    output io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: target side of the CPU byte bus.
// Holds the byte RAM plus memory-mapped I/O at addr[17:16]==2'b11:
//   0x30000 write : push nonzero byte to the UART TX FIFO
//   0x30000 read  : return rx_data (or 0) and pulse rx_pop
//   0x30004..7 rd : little-endian bytes of the cycle counter (0x30004 takes a snapshot)
//   0x30004 write : program stop, forces a 0x00 byte into the TX FIFO
// Optional feature macro: MEM_IO_TX_OVF_EN enables the sticky tx_overflow flag;
// when undefined tx_overflow is tied low and the drop tracking is not built.
module mem_io_responder #(
  parameter int RAM_ADDR_W  = 17,
  parameter int TXF_DEPTH   = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  mem_io_responder_if.slave    bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_pop,
  output logic                 program_stop,
  output logic                 tx_overflow
);

  localparam int PTR_W = $clog2(TXF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(TXF_DEPTH);
  localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(FULL_MARGIN);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic                  is_io_s;
  logic                  sel_uart_s;
  logic                  sel_cnt_s;
  logic                  sel_cnt_lo_s;
  logic [RAM_ADDR_W-1:0] ram_idx_s;
  logic                  unused_s;

  assign is_io_s      = (bus.bus_a[17:16] == 2'b11);
  assign sel_uart_s   = is_io_s && (bus.bus_a[15:0] == 16'h0000);
  assign sel_cnt_s    = is_io_s && (bus.bus_a[15:2] == 14'h0001);
  assign sel_cnt_lo_s = sel_cnt_s && (bus.bus_a[1:0] == 2'b00);
  assign ram_idx_s    = bus.bus_a[RAM_ADDR_W-1:0];
  assign unused_s     = ^{1'b0, bus.bus_a[31:18]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]       ram_r [0:(2**RAM_ADDR_W)-1];
  logic [7:0]       txf_mem_r [0:TXF_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             tx_valid_r;
  logic             buf_full_r;
  logic [7:0]       bus_din_r;
  logic [31:0]      counter_r;
  logic [31:0]      snap_r;
  logic             stop_r;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic             ram_we_s;
  logic             tx_wr_s;
  logic             stop_wr_s;
  logic             push_req_s;
  logic [7:0]       push_byte_s;
  logic             fifo_full_s;
  logic             pop_s;
  logic             push_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] free_nxt_s;
  logic [7:0]       rd_data_s;

  assign ram_we_s    = bus.bus_wr && !is_io_s;
  assign tx_wr_s     = bus.bus_wr && sel_uart_s && (bus.bus_dout != 8'h00);
  assign stop_wr_s   = bus.bus_wr && sel_cnt_lo_s;
  // After program stop every TX write, including a repeated stop write, is ignored.
  assign push_req_s  = !stop_r && (tx_wr_s || stop_wr_s);
  assign push_byte_s = stop_wr_s ? 8'h00 : bus.bus_dout;
  assign fifo_full_s = (count_r == DEPTH_C);
  assign pop_s       = tx_valid_r && tx_ready;
  // A push into a full FIFO survives only if the head leaves in the same cycle.
  assign push_s      = push_req_s && (!fifo_full_s || pop_s);
  assign free_nxt_s  = DEPTH_C - count_nxt_s;

  // Next FIFO occupancy from the push/pop pair
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Read-data source selection for the registered bus_din
  always_comb begin
    rd_data_s = 8'h00;
    if (!is_io_s) begin
      rd_data_s = ram_r[ram_idx_s];
    end else if (sel_uart_s) begin
      rd_data_s = rx_valid ? rx_data : 8'h00;
    end else if (sel_cnt_s) begin
      // Byte 0 comes from the live counter; it is also what the snapshot captures.
      case (bus.bus_a[1:0])
        2'b00:   rd_data_s = counter_r[7:0];
        2'b01:   rd_data_s = snap_r[15:8];
        2'b10:   rd_data_s = snap_r[23:16];
        default: rd_data_s = snap_r[31:24];
      endcase
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // RAM write port (contents deliberately not reset)
  always_ff @(posedge clk_in) begin
    if (ram_we_s) begin
      ram_r[ram_idx_s] <= bus.bus_dout;
    end
  end

  // TX FIFO storage write port (contents deliberately not reset)
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      txf_mem_r[wr_ptr_r] <= push_byte_s;
    end
  end

  // TX FIFO pointers, occupancy and registered status flags
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      tx_valid_r <= 1'b0;
      buf_full_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r    <= count_nxt_s;
      tx_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
      buf_full_r <= (free_nxt_s <= MARGIN_C);
    end
  end

  // Registered read data, snapshot capture, cycle counter and program stop
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus_din_r <= 8'h00;
      snap_r    <= 32'h0000_0000;
      counter_r <= 32'h0000_0000;
      stop_r    <= 1'b0;
    end else begin
      if (!bus.bus_wr) begin
        bus_din_r <= rd_data_s;
      end
      if (!bus.bus_wr && sel_cnt_lo_s) begin
        snap_r <= counter_r;
      end
      if (!stop_r) begin
        counter_r <= counter_r + 32'd1;
      end
      if (stop_wr_s) begin
        stop_r <= 1'b1;
      end
    end
  end

`ifdef MEM_IO_TX_OVF_EN
  logic drop_s;
  logic ovf_r;

  assign drop_s = push_req_s && fifo_full_s && !pop_s;

  // Sticky record of any byte dropped on a full FIFO
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end
  end

  assign tx_overflow = ovf_r;
`else
  assign tx_overflow = 1'b0;
`endif

  // rx_pop must coincide with the read cycle so the UART advances exactly when
  // bus_din captures rx_data; it is therefore decoded, not registered.
  assign rx_pop             = !bus.bus_wr && sel_uart_s && rx_valid;
  assign bus.bus_din        = bus_din_r;
  assign bus.io_buffer_full = buf_full_r;
  assign tx_data            = txf_mem_r[rd_ptr_r];
  assign tx_valid           = tx_valid_r;
  assign program_stop       = stop_r;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
// Inputs are driven just after the falling edge; outputs are sampled on the falling edge.
module tb_mem_io_responder;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic       program_stop;
  logic       tx_overflow;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc;
  int unsigned frozen;
  int unsigned e;

`ifdef MEM_IO_TX_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  mem_io_responder_if bus_if ();

  mem_io_responder dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .bus          (bus_if),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_pop       (rx_pop),
    .program_stop (program_stop),
    .tx_overflow  (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Reference count of rising edges seen out of reset (what the free-running counter should hold)
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Hard stop if the directed sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus_if.bus_a = a; bus_if.bus_dout = d; bus_if.bus_wr = 1'b1;
  endtask

  task automatic rd(input logic [31:0] a);
    bus_if.bus_a = a; bus_if.bus_dout = 8'h00; bus_if.bus_wr = 1'b0;
  endtask

  task automatic step;
    @(negedge clk_in);
  endtask

  initial begin
    rst_in = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    rd(32'h30008);
    repeat (2) step;
    #1;
    check("rst_bus_din", bus_if.bus_din, 8'h00);
    check("rst_buf_full", bus_if.io_buffer_full, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rx_pop", rx_pop, 1'b0);
    check("rst_stop", program_stop, 1'b0);
    check("rst_ovf", tx_overflow, 1'b0);
    rst_in = 1'b1;

    // 1. RAM write then read-back with one-cycle latency
    wr(32'h00100, 8'hA5); step;
    rd(32'h00100);        step;
    check("ram_a5", bus_if.bus_din, 8'hA5);
    wr(32'h1FFFF, 8'h3C); step;
    rd(32'h1FFFF);        step;
    check("ram_top", bus_if.bus_din, 8'h3C);
    rd(32'h30008);        step;
    check("io_other_rd", bus_if.bus_din, 8'h00);

    // 2. TX pushes with tx_ready=1; 0x00 is ignored
    tx_ready = 1'b1;
    wr(32'h30000, 8'h41); step;
    check("tx_v_41", tx_valid, 1'b1);
    check("tx_d_41", tx_data, 8'h41);
    wr(32'h30000, 8'h00); step;
    check("tx_zero_ign", tx_valid, 1'b0);
    wr(32'h30000, 8'h42); step;
    check("tx_v_42", tx_valid, 1'b1);
    check("tx_d_42", tx_data, 8'h42);
    rd(32'h30008);        step;
    check("tx_drained", tx_valid, 1'b0);

    // 3. Fill with tx_ready=0, nearly-full flag, drop on full, push+pop on full
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(32'h30000, 8'h61 + 8'(i)); step;
      if (i == 12) check("full_13", bus_if.io_buffer_full, 1'b0);
      if (i == 13) check("full_14", bus_if.io_buffer_full, 1'b1);
    end
    check("ovf_at_16", tx_overflow, 1'b0);
    check("head_61", tx_data, 8'h61);
    wr(32'h30000, 8'h71); step;
    check("ovf_drop", tx_overflow, OVF_EXP);
    tx_ready = 1'b1;
    wr(32'h30000, 8'h7F); step;
    check("pushpop_full", bus_if.io_buffer_full, 1'b1);
    check("pushpop_ovf", tx_overflow, OVF_EXP);
    rd(32'h30008);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), tx_data, (i < 15) ? 8'h62 + 8'(i) : 8'h7F);
      step;
    end
    check("drain_empty", tx_valid, 1'b0);
    check("drain_notfull", bus_if.io_buffer_full, 1'b0);
    tx_ready = 1'b0;

    // 4. Counter snapshot coherence at 0x000000FF
    for (int k = 0; k < 2000 && cyc != 32'd255; k++) step;
    check("cnt_sync", cyc, 32'd255);
    rd(32'h30004); step; check("cnt_b0", bus_if.bus_din, 8'hFF);
    rd(32'h30005); step; check("cnt_b1", bus_if.bus_din, 8'h00);
    rd(32'h30006); step; check("cnt_b2", bus_if.bus_din, 8'h00);
    rd(32'h30007); step; check("cnt_b3", bus_if.bus_din, 8'h00);
    rd(32'h30004); e = cyc; step;
    check("cnt_live", bus_if.bus_din, e[7:0]);

    // 5. RX pop with and without valid data
    rx_valid = 1'b1; rx_data = 8'h37;
    rd(32'h30000); #1;
    check("rx_pop_on", rx_pop, 1'b1);
    step;
    check("rx_data", bus_if.bus_din, 8'h37);
    rd(32'h30008); #1;
    check("rx_pop_once", rx_pop, 1'b0);
    rx_valid = 1'b0;
    step;
    rd(32'h30000); #1;
    check("rx_pop_off", rx_pop, 1'b0);
    step;
    check("rx_empty_rd", bus_if.bus_din, 8'h00);

    // 6. Program stop, forced 0x00, later writes ignored, counter frozen, reset
    wr(32'h30004, 8'h99); step;
    frozen = cyc;
    check("stop_set", program_stop, 1'b1);
    check("stop_tx_v", tx_valid, 1'b1);
    check("stop_tx_00", tx_data, 8'h00);
    wr(32'h30000, 8'h55); step;
    tx_ready = 1'b1;
    rd(32'h30008); step;
    check("stop_55_ign", tx_valid, 1'b0);
    tx_ready = 1'b0;
    repeat (5) step;
    rd(32'h30004); step; check("frz_b0", bus_if.bus_din, frozen[7:0]);
    rd(32'h30005); step; check("frz_b1", bus_if.bus_din, frozen[15:8]);
    rd(32'h30006); step; check("frz_b2", bus_if.bus_din, frozen[23:16]);
    rd(32'h30007); step; check("frz_b3", bus_if.bus_din, frozen[31:24]);

    rd(32'h00100); #2;
    rst_in = 1'b0; #1;
    check("rst2_bus_din", bus_if.bus_din, 8'h00);
    check("rst2_stop", program_stop, 1'b0);
    check("rst2_tx_valid", tx_valid, 1'b0);
    check("rst2_full", bus_if.io_buffer_full, 1'b0);
    check("rst2_ovf", tx_overflow, 1'b0);
    check("rst2_rx_pop", rx_pop, 1'b0);
    step;
    rst_in = 1'b1;
    rd(32'h30008); step;
    rd(32'h30004); step;
    check("rst2_cnt_restart", bus_if.bus_din, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
